// File: rtl/frame_scanout_pkg.sv
// ============================================================================
// Module      : frame_scanout_pkg
// Description : Shared SRAM_CD word format constants and pixel-lane helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package frame_scanout_pkg;

    localparam int PIX_PER_WORD = 16;
    localparam int PIX_W        = 24;
    localparam int WORD_W       = 384;
    localparam int SRAM_CD_AW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    // Lane 0 is the leftmost pixel of the word.
    function automatic logic [PIX_W-1:0] get_lane(
        input logic [WORD_W-1:0] word,
        input logic [3:0]        k
    );
        return word[int'(k)*PIX_W +: PIX_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/scanout_word_fifo.sv
// ============================================================================
// Module      : scanout_word_fifo
// Description : Two-entry show-ahead FIFO of SRAM_CD words with occupancy.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module scanout_word_fifo
    import frame_scanout_pkg::*;
(
    input  logic              clk,
    input  logic              srst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [WORD_W-1:0] o_rdata,
    output logic [1:0]        o_count
);

    logic [WORD_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/frame_scanout.sv
// ============================================================================
// Module      : frame_scanout
// Description : Raster sweep of the SRAM_CD color bank into a pixel stream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int                    H_RES     = 64,
    parameter int                    V_RES     = 48,
    parameter logic [SRAM_CD_AW-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_rd_en,
    output logic [SRAM_CD_AW-1:0] address_sram_CD,
    input  logic [WORD_W-1:0]     sram_rdata,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [PIX_W-1:0]      pix_rgb,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof
);

    localparam int N_WORDS = H_RES * V_RES / PIX_PER_WORD;
    localparam int XW      = $clog2(H_RES);
    localparam int YW      = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int CW      = $clog2(N_WORDS + 1);

    localparam logic [XW-1:0] c_X_LAST    = XW'(H_RES - 1);
    localparam logic [YW-1:0] c_Y_LAST    = YW'(V_RES - 1);
    localparam logic [CW-1:0] c_LAST_WORD = CW'(N_WORDS - 1);

    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [CW-1:0]         r_rd_cnt;
    logic [SRAM_CD_AW-1:0] r_addr;
    logic                  r_inflight;
    logic                  r_done;
    logic                  w_rd_en;

    logic [1:0]            w_fifo_cnt;
    logic [WORD_W-1:0]     w_fifo_head;
    logic [WORD_W-1:0]     w_src;
    logic                  w_push;
    logic                  w_pop;

    logic [WORD_W-1:0]     r_hold;
    logic                  r_vld;
    logic [3:0]            r_p;
    logic [PIX_W-1:0]      r_rgb;
    logic                  r_sof;
    logic                  r_eol;
    logic                  r_eof;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [XW-1:0]         w_nx;
    logic [YW-1:0]         w_ny;

    logic w_start_acc;
    logic w_hs;
    logic w_word_end;
    logic w_need;
    logic w_avail;
    logic w_load;
    logic w_bypass;
    logic w_vld_nxt;
    logic w_last_hs;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_hs        = r_vld && pix_ready;
    assign w_word_end  = w_hs && (r_p == 4'd15);
    assign w_need      = !r_vld || w_word_end;
    assign w_avail     = (w_fifo_cnt != 2'd0) || r_inflight;
    assign w_load      = w_need && w_avail;
    // An empty FIFO lets returning read data go straight into the holding
    // register; this is what gives the three-cycle first-pixel latency.
    assign w_bypass    = w_load && (w_fifo_cnt == 2'd0);
    assign w_pop       = w_load && !w_bypass;
    assign w_push      = r_inflight && !w_bypass;
    assign w_src       = w_bypass ? sram_rdata : w_fifo_head;
    assign w_vld_nxt   = w_load || (r_vld && !w_word_end);
    assign w_last_hs   = w_hs && r_eof;

    scanout_word_fifo u_fifo (
        .clk     (clk),
        .srst_n  (srst_n),
        .i_push  (w_push),
        .i_wdata (sram_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_rd_en = (w_fifo_cnt + {1'b0, r_inflight}) < 2'd2;
                if (w_rd_en && (r_rd_cnt == c_LAST_WORD)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_last_hs) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        if (w_hs) begin
            if (r_x == c_X_LAST) begin
                w_nx = '0;
                w_ny = (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                w_nx = r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state    <= ST_IDLE;
            r_rd_cnt   <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            r_done     <= w_last_hs;
            if (w_start_acc) begin
                r_addr   <= BASE_ADDR;
                r_rd_cnt <= '0;
            end else if (w_rd_en) begin
                r_addr   <= r_addr + 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // Markers follow the coordinate of the pixel that will be on the bus
    // next cycle, so they stay frozen with pix_rgb during a stall.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_hold <= '0;
            r_vld  <= 1'b0;
            r_p    <= 4'd0;
            r_rgb  <= '0;
            r_sof  <= 1'b0;
            r_eol  <= 1'b0;
            r_eof  <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (w_start_acc) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_hs) begin
                r_x <= w_nx;
                r_y <= w_ny;
            end
            if (w_load) begin
                r_hold <= w_src;
                r_p    <= 4'd0;
                r_rgb  <= get_lane(w_src, 4'd0);
            end else if (w_hs) begin
                r_p    <= r_p + 4'd1;
                r_rgb  <= get_lane(r_hold, r_p + 4'd1);
            end
            r_sof <= w_vld_nxt && (w_nx == '0) && (w_ny == '0);
            r_eol <= w_vld_nxt && (w_nx == c_X_LAST);
            r_eof <= w_vld_nxt && (w_nx == c_X_LAST) && (w_ny == c_Y_LAST);
        end
    end

    assign busy            = (r_state != ST_IDLE);
    assign done            = r_done;
    assign sram_rd_en      = w_rd_en;
    assign address_sram_CD = r_addr;
    assign pix_valid       = r_vld;
    assign pix_rgb         = r_rgb;
    assign pix_sof         = r_sof;
    assign pix_eol         = r_eol;
    assign pix_eof         = r_eof;

endmodule

`default_nettype wire

// File: tb/tb_frame_scanout.sv
// ============================================================================
// Module      : tb_frame_scanout
// Description : Scoreboard bench for frame_scanout with a behavioural SRAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_frame_scanout;

    localparam int          H    = 32;
    localparam int          V    = 2;
    localparam int          NPIX = H * V;
    localparam int          NW   = NPIX / 16;
    localparam logic [15:0] BASE = 16'h0100;

    logic         clk = 1'b0;
    logic         srst_n = 1'b0;
    logic         start = 1'b0;
    logic         pix_ready = 1'b0;
    logic [383:0] sram_rdata = '0;
    logic         busy, done, sram_rd_en, pix_valid, pix_sof, pix_eol, pix_eof;
    logic [15:0]  address_sram_CD;
    logic [23:0]  pix_rgb;

    frame_scanout #(.H_RES(H), .V_RES(V), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .srst_n          (srst_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .sram_rd_en      (sram_rd_en),
        .address_sram_CD (address_sram_CD),
        .sram_rdata      (sram_rdata),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_rgb         (pix_rgb),
        .pix_sof         (pix_sof),
        .pix_eol         (pix_eol),
        .pix_eof         (pix_eof)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          frame_id = 0;
    int          lat_frame = 0;
    int          ready_mode = 0;
    int          tot_reads = 0;
    int          tot_hs = 0;
    int          base_reads = 0;
    int          base_hs = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          last_hs_cyc = -10;
    logic [7:0]  salt = 8'h00;
    logic        stall_prev = 1'b0;
    logic [26:0] held = '0;
    logic [26:0] exp_q [$];
    logic [15:0] addr_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory content: every lane names its own word address, lane and frame salt.
    function automatic logic [383:0] word_at(input logic [15:0] a, input logic [7:0] s);
        logic [383:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w[24*k +: 24] = {a[7:0], 8'(k), s};
        return w;
    endfunction

    function automatic logic [26:0] exp_pixel(input int i, input logic [7:0] s);
        int          x;
        int          y;
        logic [15:0] a;
        x = i % H;
        y = i / H;
        a = BASE + 16'(i / 16);
        return {a[7:0], 8'(i % 16), s, (x == 0 && y == 0), (x == H - 1),
                (x == H - 1 && y == V - 1)};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        sram_rdata <= sram_rd_en ? word_at(address_sram_CD, salt) : {12{$urandom}};
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!srst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", pix_valid, 1);
                check("stall_data_held", {pix_rgb, pix_sof, pix_eol, pix_eof}, held);
            end
            if (sram_rd_en) begin
                tot_reads++;
                check("read_expected", addr_q.size() > 0, 1);
                if (addr_q.size() > 0) check("read_addr", address_sram_CD, addr_q.pop_front());
                check("read_budget", (tot_reads - base_reads) <= (tot_hs - base_hs) / 16 + 3, 1);
            end
            if (pix_valid && lat_frame != frame_id) begin
                lat_frame = frame_id;
                check("first_valid_latency", cyc - start_cyc, 3);
            end
            if (pix_valid && pix_ready) begin
                check("pixel_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    check("pixel", {pix_rgb, pix_sof, pix_eol, pix_eof}, exp_q.pop_front());
                if (ready_mode == 0 && tot_hs != base_hs) check("no_gap", cyc - last_hs_cyc, 1);
                last_hs_cyc = cyc;
                tot_hs++;
            end
            if (done) begin
                check("done_after_last_pixel", cyc - last_hs_cyc, 1);
                check("busy_low_at_done", busy, 0);
                done_cnt++;
            end
            stall_prev = pix_valid && !pix_ready;
            held       = {pix_rgb, pix_sof, pix_eol, pix_eof};
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {busy, done, sram_rd_en, pix_valid, pix_sof, pix_eol, pix_eof}, 0);
        check({tag, "_addr"}, address_sram_CD, 0);
        check({tag, "_rgb"}, pix_rgb, 0);
    endtask

    task automatic begin_frame(input int mode);
        @(posedge clk);
        #1;
        salt       = 8'($urandom);
        ready_mode = mode;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_pixel(i, salt));
        for (int n = 0; n < NW; n++) addr_q.push_back(BASE + 16'(n));
        base_reads = tot_reads;
        base_hs    = tot_hs;
        start_cyc  = cyc;
        frame_id++;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("frame_done", done_cnt - d0, 1);
        @(negedge clk);
        #1;
        check("pixels_left", exp_q.size(), 0);
        check("reads_left", addr_q.size(), 0);
        check("busy_after_done", busy, 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic wait_pixels(input int n);
        int t;
        t = 0;
        while ((tot_hs - base_hs) < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("reach_pixel", (tot_hs - base_hs) >= n, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        #2 srst_n = 1'b1;
        repeat (3) @(negedge clk);

        begin_frame(0);
        wait_done();
        exp_done++;

        begin_frame(1);
        wait_done();
        exp_done++;

        begin_frame(2);
        repeat (100) @(negedge clk);
        check("stall_reads", tot_reads - base_reads, 3);
        check("stall_no_pixels", tot_hs - base_hs, 0);
        ready_mode = 1;
        wait_done();
        exp_done++;

        begin_frame(1);
        wait_pixels(10);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        exp_done++;
        repeat (10) @(negedge clk);
        check("restart_ignored_done", done_cnt, exp_done);

        begin_frame(0);
        wait_pixels(20);
        #2 srst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk);
        #2 srst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", done_cnt, exp_done);

        begin_frame(0);
        wait_done();
        exp_done++;
        repeat (5) @(negedge clk);
        check("done_total", done_cnt, exp_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
